// File: rtl/register_bank_16x16.sv
// register_bank_16x16: sixteen 16-bit architectural registers with two
// synchronous write ports (ALU write-back and memory-load write-back).
// The load port wins when both ports target the same register; that
// collision is reported one cycle later on wr_conflict.
// Optional build macro: REG_R0_ZERO_EN -- R0 hardwired to zero, valid[0]
// tied high, writes to address 0 discarded (collisions still flagged).
module register_bank_16x16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_we,
    input  logic [3:0]  alu_addr,
    input  logic [15:0] alu_data,
    input  logic        mem_we,
    input  logic [3:0]  mem_addr,
    input  logic [15:0] mem_data,
    output logic [15:0] registers [0:15],
    output logic [15:0] valid,
    output logic        wr_conflict
);

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned DATA_W   = 16;

`ifdef REG_R0_ZERO_EN
    localparam logic [NUM_REGS-1:0] VALID_RST    = NUM_REGS'(1);
    localparam logic [NUM_REGS-1:0] WRITABLE_MSK = ~NUM_REGS'(1);
`else
    localparam logic [NUM_REGS-1:0] VALID_RST    = '0;
    localparam logic [NUM_REGS-1:0] WRITABLE_MSK = '1;
`endif

    logic [NUM_REGS-1:0] alu_sel_c;
    logic [NUM_REGS-1:0] mem_sel_c;
    logic [NUM_REGS-1:0] load_c;
    logic [DATA_W-1:0]   next_data_c [0:NUM_REGS-1];
    logic                conflict_c;

    // One-hot write decode per port and per-register load enable
    always_comb begin
        alu_sel_c = '0;
        mem_sel_c = '0;
        if (alu_we) alu_sel_c[alu_addr] = 1'b1;
        if (mem_we) mem_sel_c[mem_addr] = 1'b1;
        load_c = (alu_sel_c | mem_sel_c) & WRITABLE_MSK;
    end

    // Per-register 2:1 data select, load port has priority
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            next_data_c[i] = mem_sel_c[i] ? mem_data : alu_data;
        end
    end

    // Same-address collision between the two ports in this cycle
    always_comb begin
        conflict_c = alu_we && mem_we && (alu_addr == mem_addr);
    end

    // Register storage, one enabled flop bank per architectural register
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                registers[g] <= '0;
            end else if (load_c[g]) begin
                registers[g] <= next_data_c[g];
            end
        end
    end

    // Sticky written-since-reset flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= VALID_RST;
        end else begin
            valid <= valid | load_c | VALID_RST;
        end
    end

    // Collision flag, high for exactly the cycle after each colliding write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= conflict_c;
        end
    end

endmodule
